iir_biquad_df2_param: RTL and testbench



---
 rtl/iir_biquad_df2_param.sv | 216 +++++++++++++++++++++
 tb/tb_iir_biquad_df2_param.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_biquad_df2_param.sv
// Pipelined direct-form-II biquad section with generic widths, shadow/active
// coefficient sets with atomic commit, state clear, bypass and saturating
// arithmetic. Accepts one sample per clock; output appears two clocks later.
//
// Handshake: VIN and VOUT are valid-only strobes with no backpressure. A sample
// is consumed on every rising edge where VIN=1; each accepted sample produces
// exactly one single-cycle VOUT pulse two edges later, in order, with gaps
// preserved. DOUT holds its last value while VOUT=0; OVF is only meaningful
// while VOUT=1.
module iir_biquad_df2_param #(
   parameter int NB    = 12,
   parameter int CW    = 12,
   parameter int FRAC  = 11,
   parameter int GUARD = 2
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          VIN,
   input  logic [NB-1:0] DIN,
   input  logic          COEF_WE,
   input  logic [2:0]    COEF_SEL,
   input  logic [CW-1:0] COEF_DATA,
   input  logic          COEF_COMMIT,
   input  logic          CLR_STATE,
   input  logic          BYPASS,
   output logic          VOUT,
   output logic [NB-1:0] DOUT,
   output logic          OVF
);

   localparam int WS = NB + GUARD;
   // Wide enough for a sum of three full-precision products without wrap.
   localparam int PW = CW + WS + 3;

   localparam logic signed [PW-1:0] W_MAX = {{(PW-WS+1){1'b0}}, {(WS-1){1'b1}}};
   localparam logic signed [PW-1:0] W_MIN = {{(PW-WS+1){1'b1}}, {(WS-1){1'b0}}};
   localparam logic signed [PW-1:0] Y_MAX = {{(PW-NB+1){1'b0}}, {(NB-1){1'b1}}};
   localparam logic signed [PW-1:0] Y_MIN = {{(PW-NB+1){1'b1}}, {(NB-1){1'b0}}};

   // Coefficient index map: 0=a0, 1=a1, 2=a2, 3=b1, 4=b2.
   logic [CW-1:0] sh_q  [5];
   logic [CW-1:0] sh_d  [5];
   logic [CW-1:0] act_q [5];
   logic [CW-1:0] act_d [5];

   // Delay line.
   logic [WS-1:0] w1_q, w1_d, w2_q, w2_d;

   // Stage-2 registers: the sample's w, its view of the delay line, and the
   // feed-forward coefficients it was accepted with.
   logic          s2_vld_q, s2_vld_d;
   logic          s2_byp_q, s2_byp_d;
   logic          s2_ovf_q, s2_ovf_d;
   logic [WS-1:0] s2_w_q, s2_w_d;
   logic [WS-1:0] s2_w1_q, s2_w1_d;
   logic [WS-1:0] s2_w2_q, s2_w2_d;
   logic [CW-1:0] s2_a_q [3];
   logic [CW-1:0] s2_a_d [3];

   // Output registers.
   logic          vout_q, vout_d;
   logic [NB-1:0] dout_q, dout_d;
   logic          ovf_q, ovf_d;

   // Stage-1 / stage-2 arithmetic.
   logic signed [PW-1:0] x_ext, fb_sum, w_full, y_sum, y_full;
   logic [WS-1:0]        w_sat;
   logic                 w_ovf;
   logic [NB-1:0]        y_sat;
   logic                 y_ovf;

   function automatic logic signed [PW-1:0] sx_c(input logic [CW-1:0] v);
      return {{(PW-CW){v[CW-1]}}, v};
   endfunction

   function automatic logic signed [PW-1:0] sx_w(input logic [WS-1:0] v);
      return {{(PW-WS){v[WS-1]}}, v};
   endfunction

   // Stage 1: feedback path w = x - ((b1*w1 + b2*w2) >>> FRAC), saturated to WS bits.
   always_comb begin
      x_ext  = {{(PW-NB){DIN[NB-1]}}, DIN};
      fb_sum = sx_c(act_q[3]) * sx_w(w1_q) + sx_c(act_q[4]) * sx_w(w2_q);
      w_full = x_ext - (fb_sum >>> FRAC);
      w_sat  = w_full[WS-1:0];
      w_ovf  = 1'b0;
      if (w_full > W_MAX) begin
         w_sat = {1'b0, {(WS-1){1'b1}}};
         w_ovf = 1'b1;
      end else if (w_full < W_MIN) begin
         w_sat = {1'b1, {(WS-1){1'b0}}};
         w_ovf = 1'b1;
      end
   end

   // Coefficient shadow write and commit; a same-cycle write is visible to the commit.
   always_comb begin
      sh_d  = sh_q;
      act_d = act_q;
      for (int i = 0; i < 5; i++) begin
         if (COEF_WE && (COEF_SEL == 3'(i))) begin
            sh_d[i] = COEF_DATA;
         end
      end
      if (COEF_COMMIT) begin
         act_d = sh_d;
      end
   end

   // Delay-line update and stage-2 capture; clear has priority over the state write.
   always_comb begin
      w1_d     = w1_q;
      w2_d     = w2_q;
      s2_vld_d = VIN;
      s2_byp_d = s2_byp_q;
      s2_ovf_d = s2_ovf_q;
      s2_w_d   = s2_w_q;
      s2_w1_d  = s2_w1_q;
      s2_w2_d  = s2_w2_q;
      s2_a_d   = s2_a_q;
      if (VIN) begin
         s2_byp_d = BYPASS;
         s2_ovf_d = BYPASS ? 1'b0 : w_ovf;
         // In bypass the raw sample rides in the w slot to keep one datapath.
         s2_w_d   = BYPASS ? {{GUARD{DIN[NB-1]}}, DIN} : w_sat;
         s2_w1_d  = w1_q;
         s2_w2_d  = w2_q;
         for (int i = 0; i < 3; i++) begin
            s2_a_d[i] = act_q[i];
         end
      end
      if (CLR_STATE) begin
         w1_d = '0;
         w2_d = '0;
      end else if (VIN && !BYPASS) begin
         w2_d = w1_q;
         w1_d = w_sat;
      end
   end

   // Stage 2: feed-forward y = (a0*w + a1*w1' + a2*w2') >>> FRAC, saturated to NB bits.
   always_comb begin
      y_sum  = sx_c(s2_a_q[0]) * sx_w(s2_w_q)
             + sx_c(s2_a_q[1]) * sx_w(s2_w1_q)
             + sx_c(s2_a_q[2]) * sx_w(s2_w2_q);
      y_full = y_sum >>> FRAC;
      y_sat  = y_full[NB-1:0];
      y_ovf  = 1'b0;
      if (y_full > Y_MAX) begin
         y_sat = {1'b0, {(NB-1){1'b1}}};
         y_ovf = 1'b1;
      end else if (y_full < Y_MIN) begin
         y_sat = {1'b1, {(NB-1){1'b0}}};
         y_ovf = 1'b1;
      end
   end

   // Output register: DOUT holds between pulses, OVF is cleared between pulses.
   always_comb begin
      vout_d = s2_vld_q;
      dout_d = dout_q;
      ovf_d  = 1'b0;
      if (s2_vld_q) begin
         if (s2_byp_q) begin
            dout_d = s2_w_q[NB-1:0];
         end else begin
            dout_d = y_sat;
            ovf_d  = s2_ovf_q | y_ovf;
         end
      end
   end

   // All state registers with synchronous reset; reset drops in-flight samples.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < 5; i++) begin
            sh_q[i]  <= '0;
            act_q[i] <= '0;
         end
         w1_q     <= '0;
         w2_q     <= '0;
         s2_vld_q <= 1'b0;
         s2_byp_q <= 1'b0;
         s2_ovf_q <= 1'b0;
         s2_w_q   <= '0;
         s2_w1_q  <= '0;
         s2_w2_q  <= '0;
         for (int i = 0; i < 3; i++) begin
            s2_a_q[i] <= '0;
         end
         vout_q   <= 1'b0;
         dout_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         sh_q     <= sh_d;
         act_q    <= act_d;
         w1_q     <= w1_d;
         w2_q     <= w2_d;
         s2_vld_q <= s2_vld_d;
         s2_byp_q <= s2_byp_d;
         s2_ovf_q <= s2_ovf_d;
         s2_w_q   <= s2_w_d;
         s2_w1_q  <= s2_w1_d;
         s2_w2_q  <= s2_w2_d;
         s2_a_q   <= s2_a_d;
         vout_q   <= vout_d;
         dout_q   <= dout_d;
         ovf_q    <= ovf_d;
      end
   end

   assign VOUT = vout_q;
   assign DOUT = dout_q;
   assign OVF  = ovf_q;

endmodule

// File: tb/tb_iir_biquad_df2_param.sv
// Bench for iir_biquad_df2_param: directed scenarios plus a randomized run,
// all compared against an integer reference model of the biquad.
module tb_iir_biquad_df2_param;

   localparam int NB    = 12;
   localparam int CW    = 12;
   localparam int FRAC  = 11;
   localparam int GUARD = 2;
   localparam int WS    = NB + GUARD;
   localparam longint W_MAX = (longint'(1) <<< (WS-1)) - 1;
   localparam longint W_MIN = -(longint'(1) <<< (WS-1));
   localparam longint Y_MAX = (longint'(1) <<< (NB-1)) - 1;
   localparam longint Y_MIN = -(longint'(1) <<< (NB-1));

   // ---------------- clock / reset / signals ----------------
   logic                 clk = 1'b0;
   logic                 rst;
   logic                 vin;
   logic signed [NB-1:0] din;
   logic                 coef_we;
   logic [2:0]           coef_sel;
   logic [CW-1:0]        coef_data;
   logic                 coef_commit;
   logic                 clr_state;
   logic                 bypass;
   logic                 vout;
   logic [NB-1:0]        dout;
   logic                 ovf;

   int cyc      = 0;
   int checks   = 0;
   int failures = 0;

   // Scoreboard: expected and observed output streams.
   logic [NB-1:0] exp_q[$];
   logic          exp_o[$];
   int            exp_cyc[$];
   logic [NB-1:0] got_d[$];
   logic          got_o[$];
   int            got_cyc[$];

   // Reference model state.
   longint m_sh[5];
   longint m_act[5];
   longint m_w1, m_w2;

   iir_biquad_df2_param #(.NB(NB), .CW(CW), .FRAC(FRAC), .GUARD(GUARD)) dut (
      .CLK(clk), .RST(rst), .VIN(vin), .DIN(din),
      .COEF_WE(coef_we), .COEF_SEL(coef_sel), .COEF_DATA(coef_data),
      .COEF_COMMIT(coef_commit), .CLR_STATE(clr_state), .BYPASS(bypass),
      .VOUT(vout), .DOUT(dout), .OVF(ovf)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Capture every output pulse away from the active edge.
   always @(negedge clk) begin
      if (vout === 1'b1) begin
         got_d.push_back(dout);
         got_o.push_back(ovf);
         got_cyc.push_back(cyc);
      end
   end

   // ---------------- reference model ----------------
   function automatic longint sx(input logic [CW-1:0] v);
      return longint'($signed(v));
   endfunction

   // Applies the effect of the upcoming clock edge given the current inputs.
   task automatic model_edge();
      longint fb, w, ws, y, ys;
      logic   wo, yo;
      if (rst) begin
         for (int i = 0; i < 5; i++) begin
            m_sh[i]  = 0;
            m_act[i] = 0;
         end
         m_w1 = 0;
         m_w2 = 0;
         while (exp_cyc.size() > 0 && exp_cyc[$] > cyc) begin
            void'(exp_cyc.pop_back());
            void'(exp_q.pop_back());
            void'(exp_o.pop_back());
         end
         return;
      end
      ws = 0;
      if (vin) begin
         if (bypass) begin
            exp_q.push_back(din);
            exp_o.push_back(1'b0);
         end else begin
            fb = (m_act[3] * m_w1 + m_act[4] * m_w2) >>> FRAC;
            w  = longint'(din) - fb;
            wo = 1'b0;
            ws = w;
            if (w > W_MAX) begin ws = W_MAX; wo = 1'b1; end
            if (w < W_MIN) begin ws = W_MIN; wo = 1'b1; end
            y  = (m_act[0] * ws + m_act[1] * m_w1 + m_act[2] * m_w2) >>> FRAC;
            yo = 1'b0;
            ys = y;
            if (y > Y_MAX) begin ys = Y_MAX; yo = 1'b1; end
            if (y < Y_MIN) begin ys = Y_MIN; yo = 1'b1; end
            exp_q.push_back(NB'(ys));
            exp_o.push_back(wo | yo);
         end
         exp_cyc.push_back(cyc + 2);
      end
      if (clr_state) begin
         m_w1 = 0;
         m_w2 = 0;
      end else if (vin && !bypass) begin
         m_w2 = m_w1;
         m_w1 = ws;
      end
      if (coef_we && coef_sel < 3'd5) m_sh[coef_sel] = sx(coef_data);
      if (coef_commit) m_act = m_sh;
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      vin = 1'b0; din = '0; coef_we = 1'b0; coef_sel = '0; coef_data = '0;
      coef_commit = 1'b0; clr_state = 1'b0; bypass = 1'b0;
   endtask

   task automatic clear_q();
      exp_q.delete(); exp_o.delete(); exp_cyc.delete();
      got_d.delete(); got_o.delete(); got_cyc.delete();
   endtask

   task automatic drain();
      idle_inputs();
      repeat (4) step();
   endtask

   // Writes all five coefficients; the commit shares the cycle of the last write.
   task automatic set_coefs(input int a0, input int a1, input int a2, input int b1, input int b2);
      int v[5];
      v = '{a0, a1, a2, b1, b2};
      idle_inputs();
      for (int i = 0; i < 5; i++) begin
         coef_we = 1'b1; coef_sel = 3'(i); coef_data = CW'(v[i]);
         coef_commit = (i == 4);
         step();
      end
      idle_inputs();
      clr_state = 1'b1;
      step();
      clr_state = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         vin = i[0]; din = 12'sd100;
         step();
         checks++;
         if (vout !== 1'b0 || dout !== '0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold%0d: vout=%b dout=%0d ovf=%b, expected 0 0 0", i, vout, dout, ovf);
         end
      end
      rst = 1'b0;
      idle_inputs();
      clear_q();
      for (int i = 0; i < 6; i++) begin
         vin = (i % 2 == 0); din = 12'sd100;
         step();
      end
      drain();
      checks++;
      if (got_d.size() !== exp_q.size() || got_d.size() !== 3) begin
         failures++;
         $display("FAIL reset_count: got %0d outputs, expected %0d", got_d.size(), exp_q.size());
      end
      for (int i = 0; i < got_d.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_d[i] !== exp_q[i] || got_d[i] !== '0 || got_o[i] !== exp_o[i] || got_cyc[i] !== exp_cyc[i]) begin
            failures++;
            $display("FAIL reset_zero_out%0d: dout=%0d ovf=%b cyc=%0d, expected dout=0 ovf=%b cyc=%0d",
                     i, $signed(got_d[i]), got_o[i], got_cyc[i], exp_o[i], exp_cyc[i]);
         end
      end
   endtask

   task automatic test_impulse();
      int k[3];
      k = '{1023, 0, 0};
      clear_q();
      set_coefs(12'h400, 0, 0, 0, 0);
      vin = 1'b1; din = 12'sd2047; step();
      din = '0; step();
      step();
      drain();
      checks++;
      if (got_d.size() !== exp_q.size()) begin
         failures++;
         $display("FAIL impulse_count: got %0d outputs, expected %0d", got_d.size(), exp_q.size());
      end
      for (int i = 0; i < got_d.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_d[i] !== exp_q[i] || got_o[i] !== exp_o[i] || got_cyc[i] !== exp_cyc[i]) begin
            failures++;
            $display("FAIL impulse_out%0d: dout=%0d ovf=%b cyc=%0d, expected dout=%0d ovf=%b cyc=%0d",
                     i, $signed(got_d[i]), got_o[i], got_cyc[i], $signed(exp_q[i]), exp_o[i], exp_cyc[i]);
         end
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (i >= got_d.size() || $signed(got_d[i]) !== k[i] || got_o[i] !== 1'b0) begin
            failures++;
            $display("FAIL impulse_value%0d: dout=%0d, expected %0d", i, $signed(got_d[i]), k[i]);
         end
      end
   endtask

   task automatic test_step_gaps();
      int k[4];
      k = '{500, 750, 875, 937};
      clear_q();
      set_coefs(12'h400, 0, 0, 12'hC00, 0);
      for (int i = 0; i < 6; i++) begin
         vin = 1'b1; din = 12'sd1000; step();
      end
      drain();
      clr_state = 1'b1; step(); clr_state = 1'b0;
      for (int i = 0; i < 12; i++) begin
         vin = (i % 2 == 0); din = 12'sd1000; step();
      end
      drain();
      checks++;
      if (got_d.size() !== exp_q.size() || got_d.size() !== 12) begin
         failures++;
         $display("FAIL step_count: got %0d outputs, expected %0d", got_d.size(), exp_q.size());
      end
      for (int i = 0; i < got_d.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_d[i] !== exp_q[i] || got_o[i] !== exp_o[i] || got_cyc[i] !== exp_cyc[i]) begin
            failures++;
            $display("FAIL step_out%0d: dout=%0d ovf=%b cyc=%0d, expected dout=%0d ovf=%b cyc=%0d",
                     i, $signed(got_d[i]), got_o[i], got_cyc[i], $signed(exp_q[i]), exp_o[i], exp_cyc[i]);
         end
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= got_d.size() || $signed(got_d[i]) !== k[i]) begin
            failures++;
            $display("FAIL step_value%0d: dout=%0d, expected %0d", i, $signed(got_d[i]), k[i]);
         end
         checks++;
         if (i + 6 >= got_d.size() || $signed(got_d[i+6]) !== k[i]) begin
            failures++;
            $display("FAIL step_gap_value%0d: dout=%0d, expected %0d", i, $signed(got_d[i+6]), k[i]);
         end
      end
   endtask

   task automatic test_clr_bypass();
      int byp_val[5];
      clear_q();
      set_coefs(12'h400, 0, 0, 12'hC00, 0);
      for (int i = 0; i < 4; i++) begin
         vin = 1'b1; din = 12'sd1000; step();
      end
      vin = 1'b0; clr_state = 1'b1; step(); clr_state = 1'b0;
      for (int i = 0; i < 2; i++) begin
         vin = 1'b1; din = 12'sd1000; step();
      end
      bypass = 1'b1;
      for (int i = 0; i < 5; i++) begin
         byp_val[i] = $urandom_range(0, 4095) - 2048;
         vin = 1'b1; din = NB'(byp_val[i]); step();
      end
      bypass = 1'b0; din = 12'sd1000; step();
      drain();
      checks++;
      if (got_d.size() !== exp_q.size() || got_d.size() !== 12) begin
         failures++;
         $display("FAIL clrbyp_count: got %0d outputs, expected %0d", got_d.size(), exp_q.size());
      end
      for (int i = 0; i < got_d.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_d[i] !== exp_q[i] || got_o[i] !== exp_o[i] || got_cyc[i] !== exp_cyc[i]) begin
            failures++;
            $display("FAIL clrbyp_out%0d: dout=%0d ovf=%b cyc=%0d, expected dout=%0d ovf=%b cyc=%0d",
                     i, $signed(got_d[i]), got_o[i], got_cyc[i], $signed(exp_q[i]), exp_o[i], exp_cyc[i]);
         end
      end
      checks++;
      if (got_d.size() < 12 || $signed(got_d[4]) !== 500 || $signed(got_d[5]) !== 750) begin
         failures++;
         $display("FAIL clr_restart: dout=%0d,%0d expected 500,750", $signed(got_d[4]), $signed(got_d[5]));
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (i + 6 >= got_d.size() || $signed(got_d[i+6]) !== byp_val[i] || got_o[i+6] !== 1'b0) begin
            failures++;
            $display("FAIL bypass_value%0d: dout=%0d ovf=%b, expected %0d ovf=0", i, $signed(got_d[i+6]), got_o[i+6], byp_val[i]);
         end
      end
      checks++;
      if (got_d.size() < 12 || $signed(got_d[11]) !== 875) begin
         failures++;
         $display("FAIL bypass_frozen: dout=%0d, expected 875", $signed(got_d[11]));
      end
   endtask

   task automatic test_saturation();
      int k[4];
      logic ko[4];
      k  = '{2046, 2047, 2047, 2047};
      ko = '{1'b0, 1'b1, 1'b1, 1'b1};
      clear_q();
      set_coefs(12'h7FF, 12'h7FF, 12'h7FF, 0, 0);
      for (int i = 0; i < 4; i++) begin
         vin = 1'b1; din = 12'sd2047; step();
      end
      vin = 1'b0; clr_state = 1'b1; step(); clr_state = 1'b0;
      for (int i = 0; i < 4; i++) begin
         vin = 1'b1; din = -12'sd2048; step();
      end
      drain();
      checks++;
      if (got_d.size() !== exp_q.size() || got_d.size() !== 8) begin
         failures++;
         $display("FAIL sat_count: got %0d outputs, expected %0d", got_d.size(), exp_q.size());
      end
      for (int i = 0; i < got_d.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_d[i] !== exp_q[i] || got_o[i] !== exp_o[i] || got_cyc[i] !== exp_cyc[i]) begin
            failures++;
            $display("FAIL sat_out%0d: dout=%0d ovf=%b cyc=%0d, expected dout=%0d ovf=%b cyc=%0d",
                     i, $signed(got_d[i]), got_o[i], got_cyc[i], $signed(exp_q[i]), exp_o[i], exp_cyc[i]);
         end
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= got_d.size() || $signed(got_d[i]) !== k[i] || got_o[i] !== ko[i]) begin
            failures++;
            $display("FAIL sat_pos%0d: dout=%0d ovf=%b, expected %0d ovf=%b", i, $signed(got_d[i]), got_o[i], k[i], ko[i]);
         end
      end
      for (int i = 6; i < 8; i++) begin
         checks++;
         if (i >= got_d.size() || $signed(got_d[i]) !== -2048 || got_o[i] !== 1'b1) begin
            failures++;
            $display("FAIL sat_neg%0d: dout=%0d ovf=%b, expected -2048 ovf=1", i, $signed(got_d[i]), got_o[i]);
         end
      end
   endtask

   task automatic test_commit();
      clear_q();
      set_coefs(12'h400, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         vin = 1'b1; din = 12'sd1000;
         coef_we = (i == 4); coef_sel = 3'd0; coef_data = 12'h200; coef_commit = (i == 4);
         step();
      end
      drain();
      checks++;
      if (got_d.size() !== exp_q.size() || got_d.size() !== 10) begin
         failures++;
         $display("FAIL commit_count: got %0d outputs, expected %0d", got_d.size(), exp_q.size());
      end
      for (int i = 0; i < got_d.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_d[i] !== exp_q[i] || got_o[i] !== exp_o[i] || got_cyc[i] !== exp_cyc[i]) begin
            failures++;
            $display("FAIL commit_out%0d: dout=%0d ovf=%b cyc=%0d, expected dout=%0d ovf=%b cyc=%0d",
                     i, $signed(got_d[i]), got_o[i], got_cyc[i], $signed(exp_q[i]), exp_o[i], exp_cyc[i]);
         end
         checks++;
         if ($signed(got_d[i]) !== ((i <= 4) ? 500 : 250)) begin
            failures++;
            $display("FAIL commit_set%0d: dout=%0d, expected %0d", i, $signed(got_d[i]), (i <= 4) ? 500 : 250);
         end
      end
   endtask

   task automatic test_random();
      clear_q();
      set_coefs($urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 4095),
                $urandom_range(0, 4095), $urandom_range(0, 4095));
      for (int i = 0; i < 300; i++) begin
         vin         = ($urandom_range(0, 9) < 7);
         din         = NB'($urandom_range(0, 4095));
         clr_state   = ($urandom_range(0, 31) == 0);
         bypass      = ($urandom_range(0, 9) == 0);
         coef_we     = ($urandom_range(0, 9) == 0);
         coef_sel    = 3'($urandom_range(0, 7));
         coef_data   = CW'($urandom_range(0, 4095));
         coef_commit = ($urandom_range(0, 19) == 0);
         step();
      end
      drain();
      checks++;
      if (got_d.size() !== exp_q.size()) begin
         failures++;
         $display("FAIL random_count: got %0d outputs, expected %0d", got_d.size(), exp_q.size());
      end
      for (int i = 0; i < got_d.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_d[i] !== exp_q[i] || got_o[i] !== exp_o[i] || got_cyc[i] !== exp_cyc[i]) begin
            failures++;
            $display("FAIL random_out%0d: dout=%0d ovf=%b cyc=%0d, expected dout=%0d ovf=%b cyc=%0d",
                     i, $signed(got_d[i]), got_o[i], got_cyc[i], $signed(exp_q[i]), exp_o[i], exp_cyc[i]);
         end
      end
   endtask

   task automatic test_reset_in_flight();
      clear_q();
      set_coefs(12'h400, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         vin = 1'b1; din = 12'sd1000; step();
      end
      rst = 1'b1; step();
      rst = 1'b0; idle_inputs();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (vout !== 1'b0 || dout !== '0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL flight_reset%0d: vout=%b dout=%0d ovf=%b, expected 0 0 0", i, vout, dout, ovf);
         end
         step();
      end
      vin = 1'b1; din = 12'sd500; step();
      drain();
      checks++;
      if (got_d.size() !== exp_q.size() || got_d.size() !== 3) begin
         failures++;
         $display("FAIL flight_count: got %0d outputs, expected %0d", got_d.size(), exp_q.size());
      end
      for (int i = 0; i < got_d.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_d[i] !== exp_q[i] || got_o[i] !== exp_o[i] || got_cyc[i] !== exp_cyc[i]) begin
            failures++;
            $display("FAIL flight_out%0d: dout=%0d ovf=%b cyc=%0d, expected dout=%0d ovf=%b cyc=%0d",
                     i, $signed(got_d[i]), got_o[i], got_cyc[i], $signed(exp_q[i]), exp_o[i], exp_cyc[i]);
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      idle_inputs();
      rst = 1'b1;
      test_reset();
      test_impulse();
      test_step_gaps();
      test_clr_bypass();
      test_saturation();
      test_commit();
      test_random();
      test_reset_in_flight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
